fcl_pro_stream: RTL

- Parametrised next-generation fully-connected-layer processing element.
- Streams one input activation per beat against PARALLEL weight lanes, multiply-accumulating into PARALLEL signed accumulators over a frame of beats.
- At frame end, applies an arithmetic right shift and saturation, then presents PARALLEL output neurons over a valid/ready handshake.
- Sits between the activation/weight fetch logic and the hidden-neuron buffer of the layer sequencer.

---
 rtl/fcl_pro_stream.sv | 106 ++++++++++
 1 files changed

// File: rtl/fcl_pro_stream.sv
// fcl_pro_stream: streaming FC-layer MAC PE with shift/saturate output; FCL_PRO_RELU_EN clamps negative lanes to 0
module fcl_pro_stream #(
  parameter int WIDTH = 8,
  parameter int PARALLEL = 4,
  parameter int ACC_WIDTH = 24,
  parameter int MAX_IN = 1024
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic                          in_last,
  input  logic [WIDTH-1:0]              in_data,
  input  logic [PARALLEL*WIDTH-1:0]     in_weight,
  input  logic [$clog2(ACC_WIDTH)-1:0]  shift,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [PARALLEL*WIDTH-1:0]     out_data,
  output logic                          out_err,
  output logic                          busy
);
  localparam int SW = $clog2(ACC_WIDTH);
  localparam int CW = $clog2(MAX_IN + 1);
  localparam logic signed [ACC_WIDTH-1:0] MAXV = ACC_WIDTH'((1 << (WIDTH - 1)) - 1);
  localparam logic signed [ACC_WIDTH-1:0] MINV = ~MAXV;
  typedef enum logic {ACC, OUT} state_t;
  state_t state_q, state_d;
  logic first_q, first_d, out_err_q, out_err_d, take, frame_end;
  logic [SW-1:0] shift_q, shift_d, sh;
  logic [CW-1:0] cnt_q, cnt_d;
  logic signed [ACC_WIDTH-1:0] acc_q [PARALLEL];
  logic signed [ACC_WIDTH-1:0] acc_d [PARALLEL];
  logic signed [ACC_WIDTH-1:0] sum_w [PARALLEL];
  logic [PARALLEL*WIDTH-1:0] out_data_q, out_data_d, res_w;
  assign in_ready = state_q == ACC;
  assign out_valid = state_q == OUT;
  assign busy = !first_q || out_valid;
  assign out_data = out_data_q;
  assign out_err = out_err_q;
  assign take = in_valid && in_ready;
  assign frame_end = take && (in_last || cnt_q == CW'(MAX_IN - 1));
  assign sh = first_q ? shift : shift_q;
  for (genvar k = 0; k < PARALLEL; k++) begin : g_lane
    logic signed [2*WIDTH-1:0] prod;
    logic signed [ACC_WIDTH-1:0] pe, sum, shd;
    logic signed [WIDTH-1:0] sat, res;
    always_comb begin
      prod = $signed(in_data) * $signed(in_weight[k*WIDTH +: WIDTH]);
      pe = {{(ACC_WIDTH - 2*WIDTH){prod[2*WIDTH-1]}}, prod};
      sum = first_q ? pe : acc_q[k] + pe;
      shd = sum >>> sh;
      sat = shd > MAXV ? MAXV[WIDTH-1:0] : shd < MINV ? MINV[WIDTH-1:0] : shd[WIDTH-1:0];
`ifdef FCL_PRO_RELU_EN
      res = sat[WIDTH-1] ? '0 : sat;
`else
      res = sat;
`endif
    end
    assign sum_w[k] = sum;
    assign res_w[k*WIDTH +: WIDTH] = res;
  end
  always_comb begin
    state_d = state_q;
    first_d = first_q;
    shift_d = shift_q;
    cnt_d = cnt_q;
    acc_d = acc_q;
    out_data_d = out_data_q;
    out_err_d = out_err_q;
    if (take) begin
      acc_d = sum_w;
      cnt_d = cnt_q + 1'b1;
      first_d = 1'b0;
      shift_d = sh;
      if (frame_end) begin
        state_d = OUT;
        out_data_d = res_w;
        out_err_d = !in_last;
      end
    end
    if (out_valid && out_ready) begin
      state_d = ACC;
      first_d = 1'b1;
      cnt_d = '0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ACC;
      first_q <= 1'b1;
      shift_q <= '0;
      cnt_q <= '0;
      acc_q <= '{default: '0};
      out_data_q <= '0;
      out_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      first_q <= first_d;
      shift_q <= shift_d;
      cnt_q <= cnt_d;
      acc_q <= acc_d;
      out_data_q <= out_data_d;
      out_err_q <= out_err_d;
    end
  end
endmodule
